// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: 1-cycle ALU pass-through; loads/stores run a req/ack handshake
// on the data memory, stalling EX, with a watchdog abort. Optional forwarding outputs: MA_FWD_EN.
module memory_access_stage #(
  parameter int         DATA_WIDTH     = 16,
  parameter int         ADDR_WIDTH     = 16,
  parameter int         REG_IDX_WIDTH  = 5,
  parameter int         CTRL_WIDTH     = 5,
  parameter logic [3:0] LOAD_OP        = 4'b1100,
  parameter logic [3:0] STORE_OP       = 4'b1110,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_ex,
  input  logic [CTRL_WIDTH-1:0]    control_ex,
  input  logic [REG_IDX_WIDTH-1:0] dest_reg_index_ex,
  input  logic                     dest_reg_write_en_ex,
  input  logic [DATA_WIDTH-1:0]    result_ex,
  input  logic [DATA_WIDTH-1:0]    store_data_ex,
  output logic                     stall_ma,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic                     valid_ma,
  output logic [CTRL_WIDTH-1:0]    control_ma,
  output logic [REG_IDX_WIDTH-1:0] dest_reg_index_ma,
  output logic                     dest_reg_write_en_ma,
  output logic [DATA_WIDTH-1:0]    result_ma,
  output logic [DATA_WIDTH-1:0]    data_ma,
`ifdef MA_FWD_EN
  output logic                     fwd_valid_ma,
  output logic [REG_IDX_WIDTH-1:0] fwd_index_ma,
  output logic [DATA_WIDTH-1:0]    fwd_data_ma,
`endif
  output logic                     mem_err
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  // The counter holds the number of completed no-ack wait cycles, so the abort fires at the
  // end of the TIMEOUT_CYCLES-th request cycle.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [7:0]               wait_cnt;
  logic [CTRL_WIDTH-1:0]    cap_control;
  logic [REG_IDX_WIDTH-1:0] cap_index;
  logic                     cap_wen;
  logic [DATA_WIDTH-1:0]    cap_result;

  logic is_mem_ex;
  logic accept_mem;
  logic accept_alu;
  logic in_wait;
  logic retire_mem;
  logic timeout_hit;

  assign is_mem_ex   = (control_ex[3:0] == LOAD_OP) || (control_ex[3:0] == STORE_OP);
  assign accept_mem  = (state == IDLE) && valid_ex && is_mem_ex;
  assign accept_alu  = (state == IDLE) && valid_ex && !is_mem_ex;
  assign in_wait     = (state == WAIT_ACK);
  assign retire_mem  = in_wait && mem_ack;
  assign timeout_hit = in_wait && !mem_ack && (wait_cnt == LAST_WAIT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept_mem) state_nxt = WAIT_ACK;
      WAIT_ACK: if (mem_ack || timeout_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic: EX is held for the whole access, including the ack cycle.
  always_comb begin
    stall_ma = 1'b0;
    case (state)
      WAIT_ACK: stall_ma = 1'b1;
      default:  stall_ma = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           wait_cnt <= '0;
    else if (accept_mem) wait_cnt <= '0;
    else if (in_wait)    wait_cnt <= wait_cnt + 8'd1;
  end

  // Memory request port: fields stay stable for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept_mem) begin
      mem_req   <= 1'b1;
      mem_we    <= (control_ex[3:0] == STORE_OP);
      mem_addr  <= result_ex[ADDR_WIDTH-1:0];
      mem_wdata <= store_data_ex;
    end else if (retire_mem || timeout_hit) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_control <= '0;
      cap_index   <= '0;
      cap_wen     <= 1'b0;
      cap_result  <= '0;
    end else if (accept_mem) begin
      cap_control <= control_ex;
      cap_index   <= dest_reg_index_ex;
      cap_wen     <= dest_reg_write_en_ex;
      cap_result  <= result_ex;
    end
  end

  // Writeback bundle; fields other than valid/write-enable hold when nothing retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_ma             <= 1'b0;
      control_ma           <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      result_ma            <= '0;
      data_ma              <= '0;
    end else if (accept_alu) begin
      valid_ma             <= 1'b1;
      control_ma           <= control_ex;
      dest_reg_index_ma    <= dest_reg_index_ex;
      dest_reg_write_en_ma <= dest_reg_write_en_ex;
      result_ma            <= result_ex;
      data_ma              <= '0;
    end else if (retire_mem) begin
      valid_ma             <= 1'b1;
      control_ma           <= cap_control;
      dest_reg_index_ma    <= cap_index;
      dest_reg_write_en_ma <= mem_we ? 1'b0 : cap_wen;
      result_ma            <= cap_result;
      data_ma              <= mem_we ? '0 : mem_rdata;
    end else begin
      valid_ma             <= 1'b0;
      dest_reg_write_en_ma <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            mem_err <= 1'b0;
    else if (timeout_hit) mem_err <= 1'b1;
  end

`ifdef MA_FWD_EN
  assign fwd_valid_ma = valid_ma && dest_reg_write_en_ma;
  assign fwd_index_ma = dest_reg_index_ma;
  assign fwd_data_ma  = (control_ma[3:0] == LOAD_OP) ? data_ma : result_ma;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a transaction-level model and memory responder.
module tb_memory_access_stage;
  localparam int DW = 16, AW = 16, IW = 5, CW = 5, TMO = 4;
  localparam logic [3:0] LD = 4'b1100, ST = 4'b1110;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_ex;
  logic [CW-1:0] control_ex;
  logic [IW-1:0] dest_reg_index_ex;
  logic          dest_reg_write_en_ex;
  logic [DW-1:0] result_ex;
  logic [DW-1:0] store_data_ex;
  logic          stall_ma;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          valid_ma;
  logic [CW-1:0] control_ma;
  logic [IW-1:0] dest_reg_index_ma;
  logic          dest_reg_write_en_ma;
  logic [DW-1:0] result_ma;
  logic [DW-1:0] data_ma;
  logic          mem_err;
`ifdef MA_FWD_EN
  logic          fwd_valid_ma;
  logic [IW-1:0] fwd_index_ma;
  logic [DW-1:0] fwd_data_ma;
`endif

  memory_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .control_ex(control_ex),
    .dest_reg_index_ex(dest_reg_index_ex), .dest_reg_write_en_ex(dest_reg_write_en_ex),
    .result_ex(result_ex), .store_data_ex(store_data_ex), .stall_ma(stall_ma),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_ma(valid_ma), .control_ma(control_ma),
    .dest_reg_index_ma(dest_reg_index_ma), .dest_reg_write_en_ma(dest_reg_write_en_ma),
    .result_ma(result_ma), .data_ma(data_ma),
`ifdef MA_FWD_EN
    .fwd_valid_ma(fwd_valid_ma), .fwd_index_ma(fwd_index_ma), .fwd_data_ma(fwd_data_ma),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic          err_exp;
  logic [DW-1:0] res_exp;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit noise);
    valid_ex = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      mem_ack = 1'b0;
      chk("idle_valid", valid_ma, 0);
      chk("idle_wen", dest_reg_write_en_ma, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_stall", stall_ma, 0);
      chk("idle_result_hold", result_ma, res_exp);
      chk("idle_err", mem_err, err_exp);
    end
  endtask

  task automatic alu_op(input logic [CW-1:0] ctrl_in, input logic [IW-1:0] idx,
                        input logic en, input logic [DW-1:0] res);
    logic [CW-1:0] ctrl;
    ctrl = ctrl_in;
    if (ctrl[3:0] == LD || ctrl[3:0] == ST) ctrl[0] = ~ctrl[0];
    chk("alu_stall_pre", stall_ma, 0);
    valid_ex = 1'b1; control_ex = ctrl; dest_reg_index_ex = idx;
    dest_reg_write_en_ex = en; result_ex = res; store_data_ex = DW'($urandom);
    step();
    valid_ex = 1'b0;
    res_exp = res;
    chk("alu_valid", valid_ma, 1);
    chk("alu_ctrl", control_ma, ctrl);
    chk("alu_idx", dest_reg_index_ma, idx);
    chk("alu_wen", dest_reg_write_en_ma, en);
    chk("alu_result", result_ma, res);
    chk("alu_data", data_ma, 0);
    chk("alu_req", mem_req, 0);
    chk("alu_err", mem_err, err_exp);
`ifdef MA_FWD_EN
    chk("alu_fwd_valid", fwd_valid_ma, en);
    chk("alu_fwd_data", fwd_data_ma, res);
`endif
  endtask

  // delay = number of no-ack request cycles before the ack; delay >= TMO means no ack at all.
  task automatic mem_op(input bit is_store, input logic [AW-1:0] addr, input logic [DW-1:0] sdata,
                        input logic [IW-1:0] idx, input logic en, input int delay);
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rdata;
    bit acked;
    int stalls;
    ctrl = {1'($urandom_range(0, 1)), is_store ? ST : LD};
    rdata = mem_model.exists(addr) ? mem_model[addr] : (addr ^ 16'hA5C3);
    chk("mem_stall_pre", stall_ma, 0);
    valid_ex = 1'b1; control_ex = ctrl; dest_reg_index_ex = idx;
    dest_reg_write_en_ex = en; result_ex = addr; store_data_ex = sdata;
    step();
    chk("mem_req_set", mem_req, 1);
    chk("mem_we", mem_we, is_store);
    chk("mem_addr", mem_addr, addr);
    if (is_store) chk("mem_wdata", mem_wdata, sdata);
    chk("mem_valid_during", valid_ma, 0);
    chk("mem_wen_during", dest_reg_write_en_ma, 0);
    acked = 0;
    stalls = 0;
    for (int k = 0; k < TMO; k++) begin
      if (stall_ma) stalls++;
      chk("wait_req", mem_req, 1);
      chk("wait_addr_stable", mem_addr, addr);
      if (k == delay) begin
        mem_ack = 1'b1;
        mem_rdata = is_store ? DW'($urandom) : rdata;
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = DW'($urandom);
      if (k == delay) begin
        acked = 1;
        break;
      end
    end
    valid_ex = 1'b0;
    chk("stall_cycles", stalls, (delay < TMO) ? delay + 1 : TMO);
    chk("post_req", mem_req, 0);
    chk("post_stall", stall_ma, 0);
    if (acked) begin
      res_exp = addr;
      if (is_store) mem_model[addr] = sdata;
      chk("ret_valid", valid_ma, 1);
      chk("ret_ctrl", control_ma, ctrl);
      chk("ret_idx", dest_reg_index_ma, idx);
      chk("ret_wen", dest_reg_write_en_ma, is_store ? 1'b0 : en);
      chk("ret_result", result_ma, addr);
      chk("ret_data", data_ma, is_store ? '0 : rdata);
`ifdef MA_FWD_EN
      chk("ret_fwd_data", fwd_data_ma, is_store ? addr : rdata);
`endif
    end else begin
      err_exp = 1'b1;
      chk("tmo_valid", valid_ma, 0);
      chk("tmo_wen", dest_reg_write_en_ma, 0);
    end
    chk("post_err", mem_err, err_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; valid_ex = 1'b0; control_ex = '0; dest_reg_index_ex = '0;
    dest_reg_write_en_ex = 1'b0; result_ex = '0; store_data_ex = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    err_exp = 1'b0; res_exp = '0;
    #12;
    chk("rst_valid", valid_ma, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_ma, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_result", result_ma, 0);
    chk("rst_data", data_ma, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    step();

    alu_op(5'h01, 5'd3, 1'b1, 16'd10);
    idle(1, 0);
    mem_op(0, 16'h0040, 16'h0000, 5'd7, 1'b1, 3);
    mem_op(1, 16'h0041, 16'hBEEF, 5'd8, 1'b1, 0);
    mem_op(0, 16'h0041, 16'h0000, 5'd9, 1'b1, 1);
    idle(2, 1);
    mem_op(0, 16'h0042, 16'h0000, 5'd4, 1'b1, TMO);
    idle(2, 1);

    // Asynchronous reset in the middle of an access.
    valid_ex = 1'b1; control_ex = {1'b0, LD}; result_ex = 16'h0044;
    dest_reg_index_ex = 5'd2; dest_reg_write_en_ex = 1'b1;
    step();
    step();
    chk("pre_rst_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_valid", valid_ma, 0);
    chk("midrst_stall", stall_ma, 0);
    chk("midrst_err", mem_err, 0);
    valid_ex = 1'b0;
    #2 reset = 1'b0;
    err_exp = 1'b0; res_exp = '0;
    step();
    idle(1, 0);

    for (int i = 0; i < 6; i++)
      mem_op(i[0], 16'h0050 + 16'(i / 2), DW'($urandom), 5'(i + 1), 1'b1, 1);

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        alu_op(CW'($urandom), IW'($urandom), 1'($urandom), DW'($urandom));
      else
        mem_op(kind == 2, 16'h0040 + 16'($urandom_range(0, 7)), DW'($urandom),
               IW'($urandom), 1'($urandom), $urandom_range(0, TMO + 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
